// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-port memory among NREQ requesters
module mem_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int WR_LIMIT = 128,
  parameter int RD_LAT   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic               o_rsp_err,
  output logic [DW-1:0]      o_rsp_rdata,
  output logic               o_mem_rd_en,
  output logic               o_mem_wr_en,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic [DW-1:0]      i_mem_rdata,
  output logic               o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  // One extra bit so a limit equal to the full address space is representable.
  localparam logic [AW:0] LIMIT = (AW+1)'(WR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT
  } state_t;

  // Registered state
  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_cur;
  logic            r_we;
  logic            r_illegal;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rsp_valid;
  logic            r_rsp_err;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_mem_rd_en;
  logic            r_mem_wr_en;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  // Next-state values
  state_t          w_state;
  logic [PW-1:0]   w_ptr;
  logic [PW-1:0]   w_cur;
  logic            w_we;
  logic            w_illegal;
  logic [CW-1:0]   w_cnt;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_rsp_valid;
  logic            w_rsp_err;
  logic [DW-1:0]   w_rsp_rdata;
  logic            w_mem_rd_en;
  logic            w_mem_wr_en;
  logic [AW-1:0]   w_mem_addr;
  logic [DW-1:0]   w_mem_wdata;

  // Arbitration result and the winner's request fields
  logic            w_any;
  logic [PW-1:0]   w_win;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_illegal;

  // Requester index reached by stepping offs places past base, wrapping at NREQ.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
    int sum;
    sum = (int'(base) + offs) % NREQ;
    return PW'(sum);
  endfunction

  // Round-robin search: first active request at or after the pointer, with wrap.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && i_req[rr_index(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = rr_index(r_ptr, k);
      end
    end
  end

  assign w_sel_we      = i_req_we[w_win];
  assign w_sel_addr    = i_req_addr[int'(w_win)*AW +: AW];
  assign w_sel_wdata   = i_req_wdata[int'(w_win)*DW +: DW];
  // Writes at or above the limit are rejected and never reach the memory.
  assign w_sel_illegal = w_sel_we && ({1'b0, w_sel_addr} >= LIMIT);

  // Next-state and next-output logic; pulses default low, datapath holds.
  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_cur       = r_cur;
    w_we        = r_we;
    w_illegal   = r_illegal;
    w_cnt       = r_cnt;
    w_gnt       = '0;
    w_rsp_valid = '0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_mem_rd_en = 1'b0;
    w_mem_wr_en = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt     = NREQ'(1) << w_win;
          w_ptr     = rr_index(w_win, 1);
          w_cur     = w_win;
          w_we      = w_sel_we;
          w_illegal = w_sel_illegal;
          if (!w_sel_illegal) begin
            w_mem_rd_en = ~w_sel_we;
            w_mem_wr_en = w_sel_we;
            w_mem_addr  = w_sel_addr;
            w_mem_wdata = w_sel_wdata;
          end
          w_state = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (r_we) begin
          // Writes (accepted or rejected) answer immediately.
          w_rsp_valid = NREQ'(1) << r_cur;
          w_rsp_err   = r_illegal;
          w_state     = S_IDLE;
        end else begin
          w_cnt   = CW'(RD_LAT - 1);
          w_state = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_rsp_rdata = i_mem_rdata;
          w_rsp_valid = NREQ'(1) << r_cur;
          w_rsp_err   = 1'b0;
          w_state     = S_IDLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cur       <= '0;
      r_we        <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_cur       <= w_cur;
      r_we        <= w_we;
      r_illegal   <= w_illegal;
      r_cnt       <= w_cnt;
      r_gnt       <= w_gnt;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_mem_rd_en <= w_mem_rd_en;
      r_mem_wr_en <= w_mem_wr_en;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem_wr_en = r_mem_wr_en;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int NREQ     = 2;
  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int WR_LIMIT = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RD_LAT = 1
  logic               rst;
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, rsp_valid;
  logic               rsp_err;
  logic [DW-1:0]      rsp_rdata;
  logic               mem_rd_en, mem_wr_en;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata, mem_rdata;
  logic               busy;

  // Second instance, RD_LAT = 3, used for the mid-read reset case
  logic               rst3;
  logic [NREQ-1:0]    req3, req_we3;
  logic [NREQ*AW-1:0] req_addr3;
  logic [NREQ*DW-1:0] req_wdata3;
  logic [NREQ-1:0]    gnt3, rsp_valid3;
  logic               rsp_err3;
  logic [DW-1:0]      rsp_rdata3;
  logic               mem_rd_en3, mem_wr_en3;
  logic [AW-1:0]      mem_addr3;
  logic [DW-1:0]      mem_wdata3, mem_rdata3;
  logic               busy3;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WR_LIMIT(WR_LIMIT), .RD_LAT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err),
    .o_rsp_rdata(rsp_rdata), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WR_LIMIT(WR_LIMIT), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_req_we(req_we3), .i_req_addr(req_addr3),
    .i_req_wdata(req_wdata3), .o_gnt(gnt3), .o_rsp_valid(rsp_valid3), .o_rsp_err(rsp_err3),
    .o_rsp_rdata(rsp_rdata3), .o_mem_rd_en(mem_rd_en3), .o_mem_wr_en(mem_wr_en3),
    .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3), .o_busy(busy3)
  );

  // Test memory: preset mem[i]=i on reset, writes on negedge, read data after the sampling edge.
  logic [DW-1:0] mem [256];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  always @(posedge clk) begin
    if (rst) mem_rdata <= '0;
    else if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Read-only memory holding mem[i]=i for the second instance
  always @(posedge clk) begin
    if (rst3) mem_rdata3 <= '0;
    else if (mem_rd_en3) mem_rdata3 <= DW'(mem_addr3);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_ptr;
  int            last_w;
  logic          p_valid [NREQ];
  logic          p_we    [NREQ];
  logic [AW-1:0] p_addr  [NREQ];
  logic [DW-1:0] p_wdata [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("rd_wr_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                 = p_valid[i];
      req_we[i]              = p_we[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (p_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      p_valid[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    drive();
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
  endtask

  // One arbitration round against the model: grant, strobe, response and its latency.
  task automatic step();
    int            w;
    logic          legal;
    logic [AW-1:0] a;
    drive();
    w = model_winner();
    if (w < 0) begin
      tick();
      check("idle_gnt", 64'(gnt), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      return;
    end
    a     = p_addr[w];
    legal = !p_we[w] || (int'(a) < WR_LIMIT);
    tick();
    check("gnt", 64'(gnt), 64'(1) << w);
    check("busy", 64'(busy), 64'd1);
    check("mem_rd_en", 64'(mem_rd_en), 64'(!p_we[w]));
    check("mem_wr_en", 64'(mem_wr_en), 64'(p_we[w] && legal));
    if (legal) check("mem_addr", 64'(mem_addr), 64'(a));
    if (legal && p_we[w]) check("mem_wdata", 64'(mem_wdata), 64'(p_wdata[w]));
    m_ptr      = (w + 1) % NREQ;
    last_w     = w;
    p_valid[w] = 1'b0;
    drive();
    if (p_we[w]) begin
      tick();
      check("wr_rsp_valid", 64'(rsp_valid), 64'(1) << w);
      check("wr_rsp_err", 64'(rsp_err), 64'(!legal));
      check("wr_gnt_clear", 64'({gnt, mem_wr_en}), 64'd0);
      if (legal) ref_mem[a] = p_wdata[w];
    end else begin
      tick();
      check("rd_wait_quiet", 64'({rsp_valid, gnt, mem_rd_en}), 64'd0);
      tick();
      check("rd_rsp_valid", 64'(rsp_valid), 64'(1) << w);
      check("rd_rsp_rdata", 64'(rsp_rdata), 64'(ref_mem[a]));
      check("rd_rsp_err", 64'(rsp_err), 64'd0);
    end
    check("busy_after_rsp", 64'(busy), 64'd0);
  endtask

  task automatic set_op(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
  endtask

  initial begin
    rst3 = 1'b1; req3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0;
    last_w = -1;
    do_reset();
    rst3 = 1'b0;

    // Reset state and idle behaviour
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ctl", 64'({gnt, rsp_valid, rsp_err, mem_rd_en, mem_wr_en, mem_addr, busy}), 64'd0);
      check("idle_data", {rsp_rdata, mem_wdata}, 64'd0);
    end
    check("idle3_ctl", 64'({gnt3, rsp_valid3, rsp_err3, mem_rd_en3, mem_wr_en3, mem_addr3, busy3}), 64'd0);

    // Single read, write/readback, rejected writes and a read of a rejected address
    set_op(0, 1'b0, 8'h05, '0);           step();
    set_op(1, 1'b1, 8'h10, 32'hDEAD);     step();
    set_op(1, 1'b0, 8'h10, '0);           step();
    set_op(0, 1'b1, 8'h80, 32'h1234_5678); step();
    set_op(1, 1'b1, 8'hFF, 32'hCAFE_F00D); step();
    set_op(0, 1'b0, 8'h80, '0);           step();
    set_op(1, 1'b1, 8'h7F, 32'hA5A5_5A5A); step();
    set_op(0, 1'b0, 8'h7F, '0);           step();

    // Contention: both requesters read continuously, grants alternate from 0
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i]) set_op(i, 1'b0, AW'($urandom_range(0, 255)), '0);
      step();
      check("alternation", 64'(last_w), 64'(r % 2));
    end

    // Randomized traffic with requests held until granted
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i] && $urandom_range(0, 2) != 0)
          set_op(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
      step();
    end
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    drive();

    // Reset during RD_WAIT on the RD_LAT=3 instance
    req3 = 2'b01; req_we3 = 2'b00; req_addr3 = {8'h00, 8'h05};
    tick();
    check("r3_gnt", 64'(gnt3), 64'd1);
    req3 = 2'b00;
    tick();
    check("r3_issue", 64'({gnt3, busy3}), 64'd1);
    rst3 = 1'b1;
    tick();
    check("r3_rst_ctl", 64'({gnt3, rsp_valid3, rsp_err3, mem_rd_en3, mem_wr_en3, mem_addr3, busy3}), 64'd0);
    check("r3_rst_data", {rsp_rdata3, mem_wdata3}, 64'd0);
    rst3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("r3_no_rsp", 64'({rsp_valid3, busy3}), 64'd0);
    end
    req3 = 2'b11; req_addr3 = {8'h09, 8'h05};
    tick();
    check("r3_regrant", 64'(gnt3), 64'd1);
    req3 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("r3_wait", 64'(rsp_valid3), 64'd0);
    end
    tick();
    check("r3_rsp_valid", 64'(rsp_valid3), 64'd1);
    check("r3_rsp_rdata", 64'(rsp_rdata3), 64'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single-port 256x32 test memory between NREQ requesters. It serialises requests into one read or write strobe at a time, so read and write never coincide. It blocks writes outside the writable window and never drives them to memory. It captures read data after the memory's read latency and routes a one-cycle response back to the requester that was granted.

## Interface
- NREQ, 2, number of requesters (2..4)
- AW, 8, address width (256 words)
- DW, 32, data width
- WR_LIMIT, 128, writes allowed only to addr < WR_LIMIT
- RD_LAT, 1, cycles from the memory sampling rd_en to the arbiter capturing data_out (>=1; covers a read delay shorter than one clock)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; held high until gnt seen
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- gnt  out  NREQ  one-cycle grant pulse, one-hot
- rsp_valid  out  NREQ  one-cycle response pulse, one-hot, to the granted requester
- rsp_err  out  1  qualifies rsp_valid; 1 = write rejected (addr >= WR_LIMIT)
- rsp_rdata  out  DW  read data, valid with rsp_valid on reads
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory data_out
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, RD_WAIT.
- IDLE: if any req is high, pick the winner round-robin. Search starts at ptr, ascending with wrap. On that edge:
  - gnt[w]<=1, latch we/addr/wdata, ptr<=(w+1)%NREQ.
  - Legal op: mem_rd_en<=~we or mem_wr_en<=we, mem_addr/mem_wdata<=latched. Next state ISSUE.
  - Write with addr >= WR_LIMIT: no strobe and memory untouched. Next state ISSUE with error flagged.
- ISSUE (one cycle): clear gnt and strobes.
  - Write (legal or illegal): rsp_valid[w]<=1, rsp_err<=illegal. Next state IDLE.
  - Read: load the wait counter with RD_LAT-1. Next state RD_WAIT.
- RD_WAIT: when the counter is 0, rsp_rdata<=mem_rdata, rsp_valid[w]<=1, rsp_err<=0. Next state IDLE. Otherwise decrement.
- mem_addr/mem_wdata hold their last value outside strobes. gnt, rsp_valid and strobes are never high more than one cycle.
- req sampled in non-IDLE states is ignored. A requester still holding req is re-arbitrated normally once back in IDLE.
- Round-robin pointer advances only on a grant, including a rejected write.

## Timing
- Reset: gnt=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, ptr=0, state IDLE.
- Take T as the arbitration edge. Strobe and gnt are visible T..T+1. Memory samples rd_en at T+1 and writes on the negedge within that cycle.
- Write response: rsp_valid is visible the cycle after the ISSUE edge (T+1). Write throughput is 1 op per 2 cycles.
- Read response: rsp_valid/rsp_rdata are visible at T+1+RD_LAT. Read throughput is 1 op per 2+RD_LAT cycles.
- mem_rd_en and mem_wr_en are never both high.
- rst mid-operation forces reset values on the next edge. An in-flight read is discarded with no response, and a grant pulse in flight is cleared.
- Simultaneous requests: exactly one gnt per arbitration; the others wait.

## Test plan
- Reset then idle: every output 0 and busy=0 for 10 cycles with req=0.
- Single read, requester 0, addr 0x05, RD_LAT=1, memory preset mem[i]=i: one mem_rd_en pulse with mem_addr=5, then rsp_valid=01, rsp_rdata=5, rsp_err=0, two cycles after gnt.
- Write then readback, requester 1: write 0xDEAD to 0x10 → rsp_valid=10, rsp_err=0. Then read 0x10 → rsp_rdata=0xDEAD.
- Illegal write to 0x80 (and 0xFF): gnt pulses, mem_wr_en stays 0, rsp_err=1. A following read of 0x80 returns 0x80.
- Contention: requesters 0 and 1 hold continuous reads. Grants alternate 0,1,0,1 starting from 0 after reset. mem_rd_en and mem_wr_en are never high together. Each rsp_valid goes to the correct requester.
- Reset during RD_WAIT (RD_LAT=3, rst asserted one cycle after gnt): no rsp_valid appears, all outputs return to 0, and the next request is granted to requester 0's pointer position.
